// File: rtl/ntsc_frame_gen.sv
// Synthetic NTSC-style field generator: fvh/dv/pixel timing with a latched test pattern.
// Optional INTERLACE_EN: field_odd toggles each field and selects odd/even row numbering.
`timescale 1ns/1ps
module ntsc_frame_gen #(
    parameter int ACT_W   = 720,
    parameter int ACT_H   = 243,
    parameter int H_BLANK = 138,
    parameter int V_BLANK = 19
) (
    input  logic       vclk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] pattern,
    input  logic [9:0] box_x,
    input  logic [9:0] box_y,
    input  logic [9:0] box_w,
    input  logic [9:0] box_h,
    output logic [2:0] fvh,
    output logic       dv,
    output logic [7:0] pixel,
    output logic       field_odd,
    output logic       frame_done
);

    localparam int          LINE_CLKS = ACT_W + H_BLANK;
    localparam logic [15:0] VB_TERM   = 16'(V_BLANK * LINE_CLKS - 1);
    localparam logic [15:0] HB_TERM   = 16'(H_BLANK - 1);
    localparam logic [9:0]  COL_TERM  = 10'(ACT_W - 1);
    localparam logic [8:0]  LINE_TERM = 9'(ACT_H - 1);

    typedef enum logic [1:0] {S_VBLANK, S_VSYNC, S_ACTIVE, S_HBLANK} state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_col, w_col_nxt;
    logic [8:0]  r_line, w_line_nxt;
    logic [15:0] r_blank, w_blank_nxt;
    logic        w_latch;

    logic [1:0]  r_sh_pattern;
    logic [9:0]  r_sh_box_x, r_sh_box_y, r_sh_box_w, r_sh_box_h;
    logic        r_field_odd;

    logic [2:0]  r_fvh, w_fvh_nxt;
    logic        r_dv, w_dv_nxt;
    logic [7:0]  r_pixel, w_pixel_nxt;
    logic        r_frame_done, w_frame_done_nxt;
    logic [9:0]  w_row;

    // Box bounds use 11-bit sums so a box running past column/row 1023 never wraps.
    function automatic logic [7:0] f_pixel(input logic [1:0] pat, input logic [9:0] col,
                                           input logic [9:0] row, input logic [9:0] bx,
                                           input logic [9:0] by, input logic [9:0] bw,
                                           input logic [9:0] bh);
        logic [10:0] x_end;
        logic [10:0] y_end;
        logic        in_box;
        x_end  = {1'b0, bx} + {1'b0, bw};
        y_end  = {1'b0, by} + {1'b0, bh};
        in_box = (col >= bx) && ({1'b0, col} < x_end) && (row >= by) && ({1'b0, row} < y_end);
        case (pat)
            2'd0:    f_pixel = 8'h00;
            2'd1:    f_pixel = 8'hFF;
            2'd2:    f_pixel = in_box ? 8'hFF : 8'h10;
            default: f_pixel = col[7:0];
        endcase
    endfunction

    always_ff @(posedge vclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_VBLANK;
            r_col        <= '0;
            r_line       <= '0;
            r_blank      <= '0;
            r_sh_pattern <= '0;
            r_sh_box_x   <= '0;
            r_sh_box_y   <= '0;
            r_sh_box_w   <= '0;
            r_sh_box_h   <= '0;
            r_field_odd  <= 1'b0;
            r_fvh        <= 3'b100;
            r_dv         <= 1'b0;
            r_pixel      <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_line  <= w_line_nxt;
            r_blank <= w_blank_nxt;
            if (w_latch) begin
                r_sh_pattern <= pattern;
                r_sh_box_x   <= box_x;
                r_sh_box_y   <= box_y;
                r_sh_box_w   <= box_w;
                r_sh_box_h   <= box_h;
            end
`ifdef INTERLACE_EN
            if (w_latch) r_field_odd <= ~r_field_odd;
`else
            r_field_odd <= 1'b0;
`endif
            r_fvh        <= w_fvh_nxt;
            r_dv         <= w_dv_nxt;
            r_pixel      <= w_pixel_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Shadow config and field parity update on the edge entering VSYNC, ahead of the first active pixel.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_line_nxt  = r_line;
        w_blank_nxt = r_blank;
        w_latch     = 1'b0;
        case (r_state)
            S_VBLANK: begin
                if (r_blank == VB_TERM) begin
                    if (en) begin
                        w_state_nxt = S_VSYNC;
                        w_latch     = 1'b1;
                    end
                end else begin
                    w_blank_nxt = r_blank + 16'd1;
                end
            end
            S_VSYNC: begin
                w_state_nxt = S_ACTIVE;
                w_col_nxt   = '0;
                w_line_nxt  = '0;
            end
            S_ACTIVE: begin
                if (r_col == COL_TERM) begin
                    w_state_nxt = S_HBLANK;
                    w_blank_nxt = '0;
                end else begin
                    w_col_nxt = r_col + 10'd1;
                end
            end
            S_HBLANK: begin
                if (r_blank == HB_TERM) begin
                    if (r_line < LINE_TERM) begin
                        w_state_nxt = S_ACTIVE;
                        w_line_nxt  = r_line + 9'd1;
                        w_col_nxt   = '0;
                    end else begin
                        w_state_nxt = S_VBLANK;
                        w_blank_nxt = '0;
                    end
                end else begin
                    w_blank_nxt = r_blank + 16'd1;
                end
            end
        endcase
    end

    assign w_row = {w_line_nxt, r_field_odd};

    // Outputs are decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        w_fvh_nxt        = 3'b000;
        w_dv_nxt         = 1'b0;
        w_pixel_nxt      = 8'h00;
        w_frame_done_nxt = 1'b0;
        case (w_state_nxt)
            S_VBLANK: w_fvh_nxt = 3'b100;
            S_VSYNC:  w_fvh_nxt = 3'b010;
            S_ACTIVE: begin
                w_dv_nxt    = 1'b1;
                w_pixel_nxt = f_pixel(r_sh_pattern, w_col_nxt, w_row, r_sh_box_x,
                                      r_sh_box_y, r_sh_box_w, r_sh_box_h);
            end
            S_HBLANK: begin
                w_fvh_nxt        = (w_blank_nxt == 16'd0) ? 3'b001 : 3'b000;
                w_frame_done_nxt = (w_blank_nxt == HB_TERM) && (w_line_nxt == LINE_TERM);
            end
        endcase
    end

    assign fvh        = r_fvh;
    assign dv         = r_dv;
    assign pixel      = r_pixel;
    assign field_odd  = r_field_odd;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ntsc_frame_gen.sv
// Bench for ntsc_frame_gen: directed field scenarios plus randomized config/enable, checked
// against a position-in-field reference model.
`timescale 1ns/1ps
module tb_ntsc_frame_gen;

    localparam int AW    = 8;
    localparam int AH    = 4;
    localparam int HB    = 4;
    localparam int VBL   = 2;
    localparam int L     = AW + HB;
    localparam int VB    = VBL * L;
    localparam int FIELD = VB + 1 + AH * L;

    logic       vclk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [1:0] pattern;
    logic [9:0] box_x, box_y, box_w, box_h;
    logic [2:0] fvh;
    logic       dv;
    logic [7:0] pixel;
    logic       field_odd;
    logic       frame_done;

    int n_tests;
    int n_fail;

    int m_pos, m_fo, m_pat, m_bx, m_by, m_bw, m_bh;
    bit acc_on;
    int acc_x, acc_y, acc_n;

    ntsc_frame_gen #(.ACT_W(AW), .ACT_H(AH), .H_BLANK(HB), .V_BLANK(VBL)) dut (
        .vclk(vclk), .reset_n(reset_n), .en(en), .pattern(pattern),
        .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
        .fvh(fvh), .dv(dv), .pixel(pixel), .field_odd(field_odd), .frame_done(frame_done)
    );

    always #5 vclk = ~vclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pixel(input int c, input int row);
        case (m_pat)
            0: exp_pixel = 8'h00;
            1: exp_pixel = 8'hFF;
            2: exp_pixel = (c >= m_bx && c < m_bx + m_bw && row >= m_by && row < m_by + m_bh)
                           ? 8'hFF : 8'h10;
            default: exp_pixel = 8'(c % 256);
        endcase
    endfunction

    // Compare current outputs against the model, advance the model by one clock, wait for next sample point.
    task automatic tick();
        logic [2:0] e_fvh;
        logic       e_dv;
        logic [7:0] e_pix;
        logic       e_fd;
        int a, ln, c, row;
        e_fvh = 3'b100; e_dv = 1'b0; e_pix = 8'h00; e_fd = 1'b0;
        if (m_pos == VB) begin
            e_fvh = 3'b010;
        end else if (m_pos > VB) begin
            a = m_pos - VB - 1; ln = a / L; c = a % L; row = 2 * ln + m_fo;
            if (c < AW) begin
                e_fvh = 3'b000; e_dv = 1'b1; e_pix = exp_pixel(c, row);
                if (acc_on && dv === 1'b1 && pixel === 8'hFF) begin
                    acc_x += c; acc_y += row; acc_n++;
                end
            end else begin
                e_fvh = (c == AW) ? 3'b001 : 3'b000;
            end
            e_fd = (m_pos == FIELD - 1);
        end
        check_eq($sformatf("fvh@%0d", m_pos), 32'(fvh), 32'(e_fvh));
        check_eq($sformatf("dv@%0d", m_pos), 32'(dv), 32'(e_dv));
        check_eq($sformatf("frame_done@%0d", m_pos), 32'(frame_done), 32'(e_fd));
        check_eq($sformatf("field_odd@%0d", m_pos), 32'(field_odd), 32'(m_fo));
        if (m_pos != VB)
            check_eq($sformatf("pixel@%0d", m_pos), 32'(pixel), 32'(e_pix));
        if (m_pos == VB - 1) begin
            if (en) begin
                m_pos = VB;
                m_pat = int'(pattern); m_bx = int'(box_x); m_by = int'(box_y);
                m_bw = int'(box_w); m_bh = int'(box_h);
`ifdef INTERLACE_EN
                m_fo = 1 - m_fo;
`endif
            end
        end else begin
            m_pos = (m_pos == FIELD - 1) ? 0 : m_pos + 1;
        end
        @(negedge vclk);
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_fvh"}, 32'(fvh), 32'h4);
        check_eq({tag, "_dv"}, 32'(dv), 32'h0);
        check_eq({tag, "_pixel"}, 32'(pixel), 32'h0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        check_eq({tag, "_field_odd"}, 32'(field_odd), 32'h0);
    endtask

    // Run one whole field from VBLANK count 0; new pattern applied just after this field's VSYNC.
    task automatic run_field(input int next_pat, input bit drop_en);
        for (int i = 0; i < FIELD; i++) begin
            if (m_pos == VB + 5) pattern = 2'(next_pat);
            if (drop_en && m_pos == VB + 1 + 2 * L + 3) en = 1'b0;
            tick();
        end
    endtask

    task automatic random_config();
        pattern = 2'($urandom_range(0, 3));
        box_x = ($urandom_range(0, 7) == 0) ? 10'd1020 : 10'($urandom_range(0, 10));
        box_y = ($urandom_range(0, 7) == 0) ? 10'd1022 : 10'($urandom_range(0, 10));
        box_w = 10'($urandom_range(0, 7));
        box_h = 10'($urandom_range(0, 7));
    endtask

    initial begin
        bit found;
        int exp_y;
        n_tests = 0; n_fail = 0;
        acc_on = 0; acc_x = 0; acc_y = 0; acc_n = 0;
        m_pos = 0; m_fo = 0; m_pat = 0; m_bx = 0; m_by = 0; m_bw = 0; m_bh = 0;
        reset_n = 1'b0; en = 1'b0; pattern = 2'd0;
        box_x = '0; box_y = '0; box_w = '0; box_h = '0;
        repeat (3) @(negedge vclk);
        reset_checks("reset");

        // Box field with a mid-field box_x change that must not take effect until the next field.
        en = 1'b1; pattern = 2'd2; box_x = 10'd2; box_w = 10'd3; box_y = 10'd2; box_h = 10'd4;
        reset_n = 1'b1;
        acc_on = 1;
        for (int i = 0; i < FIELD; i++) begin
            if (m_pos == VB + 1 + L + 2) box_x = 10'd5;
            tick();
        end
        acc_on = 0;
`ifdef INTERLACE_EN
        exp_y = 24;
`else
        exp_y = 18;
`endif
        check_eq("box_count", 32'(acc_n), 32'd6);
        check_eq("box_sum_x", 32'(acc_x), 32'd18);
        check_eq("box_sum_y", 32'(acc_y), 32'(exp_y));
        if (acc_n != 0) begin
            check_eq("centroid_x", 32'(acc_x / acc_n), 32'd3);
            check_eq("centroid_y", 32'(acc_y / acc_n), 32'(exp_y / 6));
        end

        run_field(1, 1'b0);
        run_field(3, 1'b0);
        run_field(0, 1'b0);
        run_field(2, 1'b1);
        repeat (300) tick();
        en = 1'b1;
        tick();
        repeat (FIELD) tick();

        for (int i = 0; i < 12 * FIELD; i++) begin
            if ($urandom_range(0, 39) == 0) random_config();
            if ($urandom_range(0, 299) == 0) en = ~en;
            tick();
        end
        en = 1'b1;

        // Asynchronous reset between edges in the middle of an active line.
        found = 1'b0;
        for (int i = 0; i < 2 * FIELD + 400 && !found; i++) begin
            if (m_pos > VB && ((m_pos - VB - 1) % L) < AW && ((m_pos - VB - 1) / L) >= 1)
                found = 1'b1;
            else
                tick();
        end
        check_eq("reach_active", 32'(found), 32'd1);
        check_eq("pre_reset_dv", 32'(dv), 32'd1);
        #3 reset_n = 1'b0;
        #1 reset_checks("async_reset");
        @(negedge vclk);
        reset_n = 1'b1;
        m_pos = 0; m_fo = 0;
        repeat (2 * FIELD + 5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
